// File: rtl/mmcm_freq_checker.sv
// Per-channel MMCM output frequency checker: counts synchronised toggle edges over a
// fixed gate window after lock settles, flags in-range channels, and counts lock losses.

module mmcm_freq_checker_lane #(
  parameter int               CNT_W = 16,
  parameter logic [CNT_W-1:0] LO    = '0,
  parameter logic [CNT_W-1:0] HI    = '1
) (
  input  logic CLK,
  input  logic RST,
  input  logic tgl,
  input  logic meas,
  output logic pass
);
  logic [2:0]       tgl_pipe;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   d_lo, d_hi;
  logic             edge_det;

  assign edge_det = tgl_pipe[1] & ~tgl_pipe[2];

  always_ff @(posedge CLK) begin
    if (RST) begin
      tgl_pipe <= '0;
      cnt      <= '0;
    end else begin
      tgl_pipe <= {tgl_pipe[1:0], tgl};
      if (!meas)
        cnt <= '0;
      else if (edge_det && !(&cnt))
        cnt <= cnt + 1'b1;
    end
  end

  // Range test via borrow bits so constant-limit compares stay warning-free.
  assign d_lo = {1'b0, cnt} - {1'b0, LO};
  assign d_hi = {1'b0, HI} - {1'b0, cnt};
  assign pass = ~d_lo[CNT_W] & ~d_hi[CNT_W];
endmodule

module mmcm_freq_checker #(
  parameter int                        CHANNELS      = 6,
  parameter int                        CNT_W         = 16,
  parameter int                        GATE_CYCLES   = 65536,
  parameter int                        SETTLE_CYCLES = 1024,
  parameter logic [CHANNELS*CNT_W-1:0] EXP_LO        = '0,
  parameter logic [CHANNELS*CNT_W-1:0] EXP_HI        = {CHANNELS{{CNT_W{1'b1}}}}
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                I_LOCKED,
  input  logic [CHANNELS-1:0] I_CNT,
  output logic [CHANNELS-1:0] O_PASS,
  output logic                O_VALID,
  output logic                O_DONE,
  output logic [7:0]          O_LOSS_CNT
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] EVAL    = 2'd3;

  logic [1:0]          state;
  logic [1:0]          lock_pipe;
  logic                lock_s;
  logic [SW-1:0]       settle;
  logic [GW-1:0]       gate;
  logic [CHANNELS-1:0] pass;
  logic                meas;

  assign lock_s = lock_pipe[1];
  assign meas   = (state == MEASURE);
  assign O_DONE = (state == EVAL) && lock_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    mmcm_freq_checker_lane #(
      .CNT_W (CNT_W),
      .LO    (EXP_LO[i*CNT_W +: CNT_W]),
      .HI    (EXP_HI[i*CNT_W +: CNT_W])
    ) u_lane (
      .CLK  (CLK),
      .RST  (RST),
      .tgl  (I_CNT[i]),
      .meas (meas),
      .pass (pass[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      lock_pipe  <= '0;
      settle     <= '0;
      gate       <= '0;
      O_PASS     <= '0;
      O_VALID    <= 1'b0;
      O_LOSS_CNT <= '0;
    end else begin
      lock_pipe <= {lock_pipe[0], I_LOCKED};
      // Lock loss wins over everything, including a coincident EVAL.
      if (state != IDLE && !lock_s) begin
        state   <= IDLE;
        settle  <= '0;
        gate    <= '0;
        O_PASS  <= '0;
        O_VALID <= 1'b0;
        if (O_LOSS_CNT != 8'hFF)
          O_LOSS_CNT <= O_LOSS_CNT + 8'd1;
      end else begin
        case (state)
          IDLE: begin
            settle <= '0;
            gate   <= '0;
            if (lock_s)
              state <= SETTLE;
          end
          SETTLE: begin
            if (settle == SW'(SETTLE_CYCLES - 1)) begin
              settle <= '0;
              gate   <= '0;
              state  <= MEASURE;
            end else begin
              settle <= settle + 1'b1;
            end
          end
          MEASURE: begin
            if (gate == GW'(GATE_CYCLES - 1))
              state <= EVAL;
            else
              gate <= gate + 1'b1;
          end
          EVAL: begin
            O_PASS  <= pass;
            O_VALID <= 1'b1;
            gate    <= '0;
            state   <= MEASURE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mmcm_freq_checker.sv
// Scoreboard bench: stimulus queues expected window results, a monitor checks each O_DONE.

module tb_mmcm_freq_checker;
  logic       CLK, RST, I_LOCKED;
  logic [5:0] cnt_in;
  logic       sat_in;

  logic [5:0] pass6;
  logic       valid, done;
  logic [7:0] loss;
  logic       s15_pass, s15_valid, s15_done;
  logic       s14_pass, s14_valid, s14_done;
  logic [7:0] s15_loss, s14_loss;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int L, L2, D, X, cur;

  typedef struct {
    logic [5:0] pass;
    logic       s15;
    logic       s14;
    int         at;
  } exp_t;
  exp_t q[$];

  mmcm_freq_checker #(
    .CHANNELS(6), .CNT_W(16), .GATE_CYCLES(100), .SETTLE_CYCLES(10),
    .EXP_LO({6{16'd9}}), .EXP_HI({6{16'd11}})
  ) dut (
    .CLK(CLK), .RST(RST), .I_LOCKED(I_LOCKED), .I_CNT(cnt_in),
    .O_PASS(pass6), .O_VALID(valid), .O_DONE(done), .O_LOSS_CNT(loss)
  );

  mmcm_freq_checker #(
    .CHANNELS(1), .CNT_W(4), .GATE_CYCLES(100), .SETTLE_CYCLES(10),
    .EXP_LO(4'd0), .EXP_HI(4'd15)
  ) dut_s15 (
    .CLK(CLK), .RST(RST), .I_LOCKED(I_LOCKED), .I_CNT(sat_in),
    .O_PASS(s15_pass), .O_VALID(s15_valid), .O_DONE(s15_done), .O_LOSS_CNT(s15_loss)
  );

  mmcm_freq_checker #(
    .CHANNELS(1), .CNT_W(4), .GATE_CYCLES(100), .SETTLE_CYCLES(10),
    .EXP_LO(4'd0), .EXP_HI(4'd14)
  ) dut_s14 (
    .CLK(CLK), .RST(RST), .I_LOCKED(I_LOCKED), .I_CNT(sat_in),
    .O_PASS(s14_pass), .O_VALID(s14_valid), .O_DONE(s14_done), .O_LOSS_CNT(s14_loss)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Called from negedge context; returns at the negedge where cyc == c.
  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic burst(input int start, input int n, input int per, input bit sat);
    for (int j = 0; j < n; j++) begin
      at_cyc(start + j*per);
      if (sat) sat_in = 1'b1; else cnt_in[0] = 1'b1;
      at_cyc(start + j*per + 2);
      if (sat) sat_in = 1'b0; else cnt_in[0] = 1'b0;
    end
  endtask

  task automatic push(input int k, input logic [5:0] p, input logic a, input logic b);
    q.push_back('{p, a, b, L + 113 + 101*k});
  endtask

  // Monitor: each O_DONE pops one expected window; results land on the edge ending EVAL.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.at);
          chk("sat_done", {s15_done, s14_done}, 2'b11);
          @(posedge CLK);
          #1;
          chk("pass", pass6, e.pass);
          chk("valid", valid, 1'b1);
          chk("s15_pass", s15_pass, e.s15);
          chk("s14_pass", s14_pass, e.s14);
          chk("sat_valid", {s15_valid, s14_valid}, 2'b11);
        end
      end
    end
  end

  initial begin
    repeat (50000) @(posedge CLK);
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    CLK = 0; RST = 1; I_LOCKED = 0; cnt_in = '0; sat_in = 0;
    repeat (5) @(negedge CLK);
    RST = 0;

    at_cyc(20);
    chk("rst_pass", pass6, 6'd0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_loss", loss, 8'd0);

    // Lock rise; windows 0..8 of this lock period.
    at_cyc(25);
    L = 25;
    I_LOCKED = 1;
    push(0, 6'b000000, 1, 1);
    push(1, 6'b000001, 1, 1);
    push(2, 6'b000001, 1, 1);
    push(3, 6'b000001, 1, 1);
    push(4, 6'b000000, 1, 1);
    push(5, 6'b000001, 1, 0);
    push(6, 6'b000001, 1, 1);
    push(7, 6'b000000, 1, 1);
    push(8, 6'b000000, 1, 1);

    // ch0 period 10, ch1 period 8, covering windows 1..3 completely
    for (int c = L + 100; c <= L + 413; c++) begin
      at_cyc(c);
      cnt_in[0] = ((c - L - 100) % 10) < 5;
      cnt_in[1] = ((c - L - 100) % 8) < 4;
    end
    at_cyc(L + 414);
    cnt_in = '0;

    fork
      burst(L + 516 + 10, 9, 5, 1'b0);
      burst(L + 516 + 5, 20, 4, 1'b1);
    join
    burst(L + 617 + 10, 11, 5, 1'b0);
    burst(L + 718 + 10, 8, 5, 1'b0);
    burst(L + 819 + 10, 12, 5, 1'b0);

    // Lock fall reaches the synchroniser output in window 9's EVAL cycle
    at_cyc(L + 1020);
    I_LOCKED = 0;
    at_cyc(L + 1022);
    chk("evalloss_done", done, 1'b0);
    at_cyc(L + 1023);
    chk("evalloss_valid", valid, 1'b0);
    chk("evalloss_pass", pass6, 6'd0);
    chk("evalloss_loss", loss, 8'd1);
    chk("evalloss_s15_pass", s15_pass, 1'b0);

    // Relock, pass ch0 in window 0, drop lock at gate count 50 of window 1
    L2 = L + 1030;
    at_cyc(L2);
    I_LOCKED = 1;
    q.push_back('{6'b000001, 1'b1, 1'b1, L2 + 113});
    burst(L2 + 30, 10, 5, 1'b0);
    D = L2 + 164;
    at_cyc(D);
    I_LOCKED = 0;
    at_cyc(D + 2);
    chk("midloss_valid_hold", valid, 1'b1);
    chk("midloss_pass_hold", pass6, 6'b000001);
    at_cyc(D + 3);
    chk("midloss_valid", valid, 1'b0);
    chk("midloss_pass", pass6, 6'd0);
    chk("midloss_loss", loss, 8'd2);

    cur = D + 10;
    for (int r = 0; r < 300; r++) begin
      at_cyc(cur);
      I_LOCKED = 1;
      at_cyc(cur + 20);
      I_LOCKED = 0;
      cur += 26;
    end
    at_cyc(cur);
    chk("loss_sat", loss, 8'd255);
    chk("loss_sat_s15", s15_loss, 8'd255);
    chk("loss_sat_s14", s14_loss, 8'd255);

    // Reset in the middle of a window
    at_cyc(cur + 1);
    I_LOCKED = 1;
    X = cur + 61;
    at_cyc(X);
    RST = 1;
    at_cyc(X + 1);
    chk("midrst_pass", pass6, 6'd0);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_loss", loss, 8'd0);
    RST = 0;
    at_cyc(X + 15);
    chk("postrst_loss", loss, 8'd0);
    chk("postrst_valid", valid, 1'b0);
    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmcm_freq_checker.md
# mmcm_freq_checker

Per-channel frequency checker that sits directly downstream of the MMCM tester on the board top level. It consumes the tester's lock flag and its asynchronous per-output divided-clock toggle bits. It counts rising edges of each bit over a fixed gate window in the CLK domain and drives a pass flag per channel when the count falls inside a programmed range. It also keeps a saturating count of lock-loss events for the LED/debug outputs.

## Interface
- CHANNELS, 6, number of toggle inputs checked (1..8)
- CNT_W, 16, edge-counter and limit width per channel
- GATE_CYCLES, 65536, CLK cycles per measurement window (>= 2)
- SETTLE_CYCLES, 1024, CLK cycles waited after lock rises before the first window (>= 1)
- EXP_LO, {CHANNELS{CNT_W'd0}}, packed per-channel inclusive lower limits; channel i at bits [i*CNT_W +: CNT_W]
- EXP_HI, {CHANNELS{CNT_W'hFFFF}}, packed per-channel inclusive upper limits, same packing

- CLK  in  1  system clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- I_LOCKED  in  1  MMCM lock flag, asynchronous
- I_CNT  in  CHANNELS  divided-clock toggle bits, asynchronous
- O_PASS  out  CHANNELS  per-channel result of the last completed window
- O_VALID  out  1  high while O_PASS holds a result from the current lock period
- O_DONE  out  1  one-cycle pulse when a window is evaluated
- O_LOSS_CNT  out  8  saturating count of lock-loss events

## Operation
- Synchronisers: I_LOCKED and each I_CNT bit pass through a 2-FF synchroniser. A third register per I_CNT bit gives rising-edge detect, asserted when current=1 and previous=0.
- FSM states: IDLE, SETTLE, MEASURE, EVAL.
- IDLE: clear the settle counter, gate counter and edge counters. Go to SETTLE when synced lock = 1.
- SETTLE: count SETTLE_CYCLES cycles, then go to MEASURE with the gate counter at 0.
- MEASURE:
  - Each cycle, every channel counter increments on its detected edge. Counters saturate at 2^CNT_W-1.
  - The gate counter runs 0..GATE_CYCLES-1. The cycle with gate = GATE_CYCLES-1 still counts edges, then the FSM goes to EVAL.
- EVAL (one cycle):
  - O_PASS[i] <= (EXP_LO[i] <= cnt[i] <= EXP_HI[i]).
  - O_VALID <= 1 and O_DONE = 1.
  - Clear the edge counters and gate counter, then go to MEASURE. Windows repeat back-to-back with a 1-cycle EVAL gap; edges detected during EVAL are discarded.
- Lock loss: synced lock falls while in SETTLE, MEASURE or EVAL.
  - Next state is IDLE; O_PASS <= 0 and O_VALID <= 0.
  - O_LOSS_CNT increments, saturating at 255.
  - Lock loss has priority over EVAL in the same cycle: no O_DONE pulse and no result update.
  - A fall observed while in IDLE is not counted. Lock was never held there.
- Comparison is unsigned, width CNT_W. A saturated count compares as 2^CNT_W-1.
- Input toggle rates must be below CLK/4. Faster inputs undercount; the block does not flag this.

## Timing
- Reset values: FSM = IDLE; O_PASS = 0, O_VALID = 0, O_DONE = 0, O_LOSS_CNT = 0; all counters and synchroniser flops = 0.
- RST mid-window: the window is aborted, all outputs return to reset values on the next edge, and the reset does not count as a lock loss.
- Input-to-edge-pulse latency: 3 CLK cycles (2 sync + 1 edge register).
- Lock rise to first MEASURE cycle: 2 (sync) + 1 (IDLE) + SETTLE_CYCLES cycles.
- Window period: GATE_CYCLES + 1 cycles. O_PASS and O_VALID change on the edge ending EVAL, coincident with O_DONE.
- Lock fall to O_VALID low: 3 CLK cycles (2 sync + 1 register).

## Test plan
- Reset and lock with no toggles:
  - Setup: GATE_CYCLES=100, SETTLE_CYCLES=10, EXP_LO=9, EXP_HI=11 for all channels; hold I_LOCKED=0, then release RST.
  - Required: all outputs 0, FSM stays IDLE.
  - Then raise lock with no toggles: first O_DONE 113 cycles after the lock rise, O_PASS=0, O_VALID=1.
- Exact edge counts, same setup:
  - Stimulus: ch0 toggles with a period of 10 CLK (10 rising edges per window); ch1 with a period of 8 (12 or 13 edges).
  - Required: O_PASS[0]=1 and O_PASS[1]=0 on every O_DONE; O_DONE pulses every 101 cycles.
- Limit boundaries:
  - Stimulus: exactly 9 edges and exactly 11 edges inside one window, placed away from the window edges.
  - Required: pass in both cases. 8 edges or 12 edges give fail.
- Lock loss mid-window:
  - Stimulus: drop I_LOCKED at gate count 50.
  - Required: O_VALID=0 and O_PASS=0 three cycles later; no O_DONE; O_LOSS_CNT=1.
  - Repeat 300 times: O_LOSS_CNT=255.
- Saturation:
  - Setup: CNT_W=4, EXP_HI=15.
  - Stimulus: 20 edges in a window.
  - Required: count holds at 15 and O_PASS=1; with EXP_HI=14, O_PASS=0.
- Simultaneous lock loss and EVAL:
  - Stimulus: the lock fall reaches the sync output exactly in the EVAL cycle.
  - Required: no O_DONE pulse, O_PASS unchanged from 0 and O_VALID=0.
